// File: rtl/mitch_trunc_pipe_if.sv
// Operand/result handshake bundle for the pipelined truncated Mitchell multiplier.
// The producer/consumer side uses the master modport and the multiplier uses the slave modport.
interface mitch_trunc_pipe_if #(
    parameter int N     = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       x;
    logic [N-1:0]       y;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*N-1:0]     p;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, x, y, in_tag, out_ready,
        input  in_ready, out_valid, p, out_tag
    );

    modport slave (
        input  in_valid, x, y, in_tag, out_ready,
        output in_ready, out_valid, p, out_tag
    );
endinterface

// File: rtl/mitch_trunc_pipe.sv
// Three-stage valid/ready pipelined signed Mitchell log multiplier with truncated fractions.
// The stages are: S1 magnitude and log, S2 log add, S3 antilog and sign. S3 holds the output.
module mitch_trunc_pipe #(
    parameter int N     = 8,
    parameter int W     = 5,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mitch_trunc_pipe_if.slave  bus
);
    localparam int KW = $clog2(N);
    localparam int FW = W - 1;
    localparam int PW = 2 * N;
    localparam logic [N-1:0]  ONE_N  = N'(1);
    localparam logic [PW-1:0] ONE_P  = PW'(1);
    localparam logic [KW:0]   FW_K   = (KW+1)'(FW);

    function automatic logic [KW-1:0] lead_one(input logic [N-1:0] a);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Normalise so the leading one sits at bit N-1; the fraction is what follows it.
    function automatic logic [FW-1:0] frac_of(input logic [N-1:0] a, input logic [KW-1:0] k);
        logic [N-1:0] n;
        n = a << (KW'(N-1) - k);
        return n[N-2 -: FW];
    endfunction

    logic               s1_valid, s2_valid, s3_valid;
    logic               adv1, adv2, adv3, in_fire;

    logic [KW-1:0]      s1_kx, s1_ky;
    logic [FW-1:0]      s1_fx, s1_fy;
    logic               s1_sp, s1_z;
    logic [TAG_W-1:0]   s1_tag;

    logic [KW:0]        s2_k;
    logic [FW-1:0]      s2_f;
    logic               s2_sp, s2_z;
    logic [TAG_W-1:0]   s2_tag;

    logic [PW-1:0]      s3_p;
    logic [TAG_W-1:0]   s3_tag;

    logic [N-1:0]       ax, ay;
    logic [W-1:0]       f_sum;
    logic [KW:0]        k_sum;
    logic [PW-1:0]      m_ext, mag, p_c;

    assign adv3    = ~s3_valid | bus.out_ready;
    assign adv2    = ~s2_valid | adv3;
    assign adv1    = ~s1_valid | adv2;
    assign in_fire = bus.in_valid & adv1;

    // Exact magnitudes: the most negative operand maps to 2^(N-1), which still fits unsigned.
    always_comb begin
        ax = bus.x[N-1] ? (~bus.x + ONE_N) : bus.x;
        ay = bus.y[N-1] ? (~bus.y + ONE_N) : bus.y;
    end

    always_comb begin
        f_sum = {1'b0, s1_fx} + {1'b0, s1_fy};
        k_sum = (KW+1)'(s1_kx) + (KW+1)'(s1_ky) + (KW+1)'(f_sum[FW]);
    end

    always_comb begin
        m_ext = PW'({1'b1, s2_f});
        if (s2_k >= FW_K) begin
            mag = m_ext << (s2_k - FW_K);
        end else begin
            mag = m_ext >> (FW_K - s2_k);
        end
        p_c = '0;
        if (!s2_z) begin
            p_c = s2_sp ? (~mag + ONE_P) : mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_kx    <= '0;
            s1_ky    <= '0;
            s1_fx    <= '0;
            s1_fy    <= '0;
            s1_sp    <= 1'b0;
            s1_z     <= 1'b0;
            s1_tag   <= '0;
        end else if (adv1) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_kx  <= lead_one(ax);
                s1_ky  <= lead_one(ay);
                s1_fx  <= frac_of(ax, lead_one(ax));
                s1_fy  <= frac_of(ay, lead_one(ay));
                s1_sp  <= bus.x[N-1] ^ bus.y[N-1];
                s1_z   <= (ax == '0) | (ay == '0);
                s1_tag <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_k     <= '0;
            s2_f     <= '0;
            s2_sp    <= 1'b0;
            s2_z     <= 1'b0;
            s2_tag   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_k   <= k_sum;
                s2_f   <= f_sum[FW-1:0];
                s2_sp  <= s1_sp;
                s2_z   <= s1_z;
                s2_tag <= s1_tag;
            end
        end
    end

    // p and out_tag only change when a new result moves in, so a stalled output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_p     <= '0;
            s3_tag   <= '0;
        end else if (adv3) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_p   <= p_c;
                s3_tag <= s2_tag;
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s3_valid;
    assign bus.p         = s3_p;
    assign bus.out_tag   = s3_tag;
endmodule
